wb_mem_slave: RTL
=================

Name: wb_mem_slave

Overview:
Pipelined Wishbone-style memory responder: the slave end of the CPU instruction and data bus ports (cyc/stb/we/be/addr → ack/data/stall). It sits between the CPU core and on-chip RAM, and serves as both the instruction and the data memory model. Accepted requests are queued in a request FIFO and serviced in order by a fixed-latency access FSM. The slave raises stall when the queue is full.

Parameters:
MEM_WORDS, 1024, number of 32-bit words; power of two.
LATENCY, 1, cycles from pop to ack; minimum 1.
FIFO_DEPTH, 4, request queue entries; power of two, ≥2.

Ports:
sys_clk  in  1  clock; all state updates on the rising edge.
sys_rst  in  1  asynchronous reset, active-low.
cyc_in  in  1  bus cycle active.
stb_in  in  1  request strobe.
we_in  in  1  1 = write, 0 = read.
be_in  in  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
addr_in  in  32  byte address; bits [1:0] ignored.
data_in  in  32  write data.
ack_out  out  1  one-cycle response strobe per accepted request.
data_out  out  32  read data, valid when ack_out=1 for a read.
stall_out  out  1  request not accepted this cycle.

Behaviour:
- Reset (sys_rst=0, asynchronous): ack_out=0, data_out=0, stall_out=0, FIFO empty, FSM=IDLE, counter=0. Memory contents are not reset.
- Accept: a request is accepted in a cycle where cyc_in & stb_in & !stall_out. The FIFO stores {we, be, word index, wdata}.
- Word index = addr_in[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo MEM_WORDS.
- stall_out is registered. It equals 1 when the FIFO count is FIFO_DEPTH, or when the count is FIFO_DEPTH-1 with a push and no pop this cycle.
- A simultaneous push and pop on a full FIFO is not possible, because pushes are blocked while stall_out=1.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, perform the access, and load counter=LATENCY-1. Go to RESP if LATENCY=1, else WAIT.
  - WAIT: decrement the counter; go to RESP when it reaches 1.
  - RESP: ack_out=1 for one cycle. If the FIFO is non-empty, pop the next request in the same cycle, perform its access, and reload (back-to-back). Otherwise go to IDLE.
- Access at pop:
  - Write: update each byte lane whose be bit is 1; other lanes are unchanged.
  - Read: register mem[index] into a holding register.
  - data_out is driven from the holding register during RESP of a read. It holds its last value otherwise, including on write acks.
- Latency: with the slave empty and a request accepted in cycle 0, the ack is in cycle 1+LATENCY. Steady-state throughput is one ack every LATENCY cycles.
- Ordering: strictly in order. A read queued after a write to the same word returns the written data.
- cyc_in falling while work is outstanding:
  - The FIFO is flushed and the FSM goes to IDLE next cycle.
  - ack_out is forced to 0 in any cycle where cyc_in=0.
  - A write already popped is committed; queued writes that were not yet popped are discarded.
- stb_in without cyc_in is ignored.
- be_in=0 on a write is still acked and modifies nothing.
- A reset in the middle of an operation aborts everything; no ack is issued afterwards.

Decomposition:
- Shared package wb_bus_pkg: bus widths (ADDR_W=32, DATA_W=32, BE_W=4), the request struct/field layout, and the FSM state encoding (IDLE, WAIT, RESP).
- One sub-module, wb_req_fifo:
  - Synchronous FIFO with an async active-low reset and a synchronous flush.
  - Outputs: count, full, empty.
  - Parameterised width and depth.
- The memory array is inferred inside wb_mem_slave.

Test Plan:
1. LATENCY=1: write addr 0x10, data 0xDEADBEEF, be=0xF in cycle 0, then read 0x10. Required: acks in cycles 2 and 3; read ack has data_out=0xDEADBEEF.
2. Byte enables: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0x5, then read. Required: read returns 0x11BB33DD.
3. Back-pressure, LATENCY=3, FIFO_DEPTH=4: 8 consecutive reads.
   - stall_out goes to 1 once 4 requests are queued and clears as pops occur.
   - Exactly 8 acks, 3 cycles apart, in address order.
4. Wrap: MEM_WORDS=1024; write 0x5 to addr 0x1000, then read addr 0x0. Required: data_out=0x5.
5. Abort, LATENCY=4: queue 3 writes, then drop cyc_in one cycle after the first pop.
   - No acks while cyc_in=0.
   - Only the first write is visible on later reads.
6. Reset: assert sys_rst=0 asynchronously mid-WAIT. Required: ack_out, stall_out, data_out=0 immediately; no ack after release.

Source files
------------

// File: rtl/wb_bus_pkg.sv
// Shared bus definitions for the Wishbone-style memory slave.
// Contents:
//   ADDR_W / DATA_W / BE_W  bus widths
//   IDX_W                   widest word index an address can carry
//   wb_req_t                request queue entry {we, be, word index, wdata}
//   wb_state_e              access FSM state encoding
//   be_mask()               expands byte enables into a 32-bit lane mask
package wb_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int IDX_W  = ADDR_W - 2;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  localparam int REQ_W = $bits(wb_req_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Each enabled byte lane becomes eight ones in the returned mask.
  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b0}};
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through read port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear of all entries (wins over push/pop)
//   push/push_data enqueue (ignored while full)
//   pop/pop_data   dequeue; pop_data shows the head entry combinationally
//   count/full/empty occupancy status
module wb_req_fifo
  import wb_bus_pkg::*;
#(
  parameter int WIDTH = REQ_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign pop_data  = store_r[rd_ptr_r];

  // Entry storage; no reset needed because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      store_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone-style memory responder (instruction/data memory model).
// Requests accepted on cyc&stb&!stall are queued and serviced in order by a
// fixed-latency FSM; each accepted request produces exactly one ack unless
// cyc drops or reset intervenes.
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-low reset
//   cyc_in, stb_in     bus cycle / request strobe
//   we_in, be_in       write enable, byte-lane enables
//   addr_in, data_in   byte address (bits [1:0] ignored), write data
//   ack_out            one-cycle response strobe, masked by cyc_in
//   data_out           read data, updated only when a read is acked
//   stall_out          registered back-pressure
module wb_mem_slave
  import wb_bus_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cyc_in,
  input  logic              stb_in,
  input  logic              we_in,
  input  logic [BE_W-1:0]   be_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] data_out,
  output logic              stall_out
);

  localparam int MIDX_W  = $clog2(MEM_WORDS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W   = $clog2(LATENCY + 1);
  localparam bit LAT_ONE = (LATENCY == 1);

  logic [DATA_W-1:0] mem_r [MEM_WORDS];

  wb_state_e         state_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] dout_r;
  logic              rd_pend_r;
  logic              stall_r;

  logic              push_s;
  logic              pop_s;
  logic              stall_nxt_s;
  wb_req_t           req_in_s;
  wb_req_t           pop_req_s;
  logic [REQ_W-1:0]  pop_data_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [MIDX_W-1:0] pop_idx_s;
  logic [DATA_W-1:0] mem_rd_s;
  logic [DATA_W-1:0] wmask_s;
  logic              unused_s;

  // Address bits outside the word index are deliberately dropped (wrap).
  assign req_in_s.we    = we_in;
  assign req_in_s.be    = be_in;
  assign req_in_s.idx   = IDX_W'(addr_in[MIDX_W+1:2]);
  assign req_in_s.wdata = data_in;

  assign push_s    = cyc_in & stb_in & ~stall_r & ~fifo_full_s;
  // Pops only happen from IDLE or RESP, and never once cyc has dropped.
  assign pop_s     = cyc_in & ~fifo_empty_s & ((state_r == IDLE) | (state_r == RESP));
  assign pop_req_s = wb_req_t'(pop_data_s);
  assign pop_idx_s = pop_req_s.idx[MIDX_W-1:0];
  assign mem_rd_s  = mem_r[pop_idx_s];
  assign wmask_s   = be_mask(pop_req_s.be);

  assign ack_out   = (state_r == RESP) & cyc_in;
  assign data_out  = dout_r;
  assign stall_out = stall_r;

  assign unused_s  = ^{addr_in[1:0], addr_in[ADDR_W-1:MIDX_W+2],
                       pop_req_s.idx[IDX_W-1:MIDX_W]};

  wb_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst),
    .flush     (~cyc_in),
    .push      (push_s),
    .push_data (req_in_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Next stall: full now, or about to become full from a lone push.
  always_comb begin
    stall_nxt_s = 1'b0;
    if (!cyc_in) begin
      stall_nxt_s = 1'b0;
    end else if (fifo_count_s == CNT_W'(FIFO_DEPTH)) begin
      stall_nxt_s = 1'b1;
    end else if ((fifo_count_s == CNT_W'(FIFO_DEPTH - 1)) && push_s && !pop_s) begin
      stall_nxt_s = 1'b1;
    end else begin
      stall_nxt_s = 1'b0;
    end
  end

  // Memory array: writes commit at pop time, merging only enabled lanes.
  always_ff @(posedge sys_clk) begin
    if (pop_s && pop_req_s.we) begin
      mem_r[pop_idx_s] <= (mem_rd_s & ~wmask_s) | (pop_req_s.wdata & wmask_s);
    end
  end

  // Access FSM with registered stall, read holding register and data output.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r   <= IDLE;
      lat_cnt_r <= LAT_W'(0);
      hold_r    <= {DATA_W{1'b0}};
      dout_r    <= {DATA_W{1'b0}};
      rd_pend_r <= 1'b0;
      stall_r   <= 1'b0;
    end else begin
      stall_r <= stall_nxt_s;
      if (!cyc_in) begin
        state_r   <= IDLE;
        lat_cnt_r <= LAT_W'(0);
      end else if (pop_s) begin
        hold_r    <= mem_rd_s;
        rd_pend_r <= ~pop_req_s.we;
        lat_cnt_r <= LAT_W'(LATENCY - 1);
        if (LAT_ONE) begin
          // No wait states: the ack cycle follows immediately, so load the
          // output straight from the array instead of via the holding register.
          state_r <= RESP;
          if (!pop_req_s.we) begin
            dout_r <= mem_rd_s;
          end
        end else begin
          state_r <= WAIT;
        end
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          WAIT: begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
            if (lat_cnt_r == LAT_W'(1)) begin
              state_r <= RESP;
              if (rd_pend_r) begin
                dout_r <= hold_r;
              end
            end else begin
              state_r <= WAIT;
            end
          end
          RESP:    state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule
